// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a TXDATA/STATUS window, byte FIFO and 8N1 serializer.
// Define MMIO_UART_TX_PARITY_EN for an even-parity bit between data and stop (STATUS bit4 reads 1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic        hit,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic sel_tx, sel_status;
  assign hit        = (addr >= BASE_ADDR) && (addr <= BASE_ADDR + 32'd7);
  assign sel_tx     = (addr == BASE_ADDR);
  assign sel_status = (addr == BASE_ADDR + 32'd4);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          full, empty, push_req, push_ok, pop;

  // Fullness is taken from the registered count, so a same-cycle pop never rescues a push.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = write_enable && sel_tx;
  assign push_ok  = push_req && !full;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && full)
        overflow_q <= 1'b1;
      else if (write_enable && sel_status && write_data[3])
        overflow_q <= 1'b0;
    end
  end

  state_t        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    frame_q;
  logic          tx_q, busy_q, tx_d, bit_done;

  assign bit_done = (bit_cnt_q == '0);
  assign pop      = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = frame_q[bit_idx_q];
`ifdef MMIO_UART_TX_PARITY_EN
      S_PARITY: tx_d = ^frame_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // tx and busy are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= (state_q != S_IDLE) || !empty;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            frame_q   <= mem_q[rd_ptr_q];
            bit_cnt_q <= BIT_LOAD;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            bit_cnt_q <= BIT_LOAD;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bit_cnt_q <= BIT_LOAD;
            if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            bit_cnt_q <= BIT_LOAD;
            state_q   <= S_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            if (pop) begin
              frame_q   <= mem_q[rd_ptr_q];
              bit_cnt_q <= BIT_LOAD;
              state_q   <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [31:0] status;
  always_comb begin
    status     = '0;
    status[0]  = full;
    status[1]  = empty;
    status[2]  = (state_q != S_IDLE);
    status[3]  = overflow_q;
`ifdef MMIO_UART_TX_PARITY_EN
    status[4]  = 1'b1;
`endif
    status[15:8] = 8'(count_q);
  end

  assign read_data = sel_status ? status : 32'h0;
  assign tx        = tx_q;
  assign busy      = busy_q;

  logic unused_wdata;
  assign unused_wdata = ^write_data[31:8];
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: random and directed stimulus for mmio_uart_tx checked against a frame-level reference model.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;
  localparam int          CPB   = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          FBITS = 11;
  localparam logic [31:0] CAP   = 32'h10;
`else
  localparam int          FBITS = 10;
  localparam logic [31:0] CAP   = 32'h0;
`endif
  localparam int          FRAME = FBITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic        hit;
  logic [31:0] read_data;
  logic        tx;
  logic        busy;

  int tests = 0;
  int fails = 0;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .write_data  (write_data),
    .write_enable(write_enable),
    .hit         (hit),
    .read_data   (read_data),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a byte queue plus the edge at which the current frame's FSM entered START.
  logic [7:0] mq [$];
  bit         m_active;
  bit         m_ovf;
  int         m_sstart;
  int         m_edge;
  logic [7:0] m_cur;
  logic       exp_tx;
  logic       exp_busy;

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_ovf    = 0;
    m_sstart = 0;
    m_edge   = 0;
    m_cur    = '0;
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
  endtask

  function automatic logic model_bit(input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    if (FBITS == 11 && b == 9) return ^m_cur;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = CAP;
    s[0] = (mq.size() == DEPTH);
    s[1] = (mq.size() == 0);
    s[2] = m_active;
    s[3] = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd7);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (a == BASE + 32'd4) ? model_status() : 32'h0;
  endfunction

  task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int   sz;
    logic full_b;
    m_edge++;
    sz       = mq.size();
    exp_tx   = m_active ? model_bit(m_edge - 1 - m_sstart) : 1'b1;
    exp_busy = m_active || (sz != 0);
    full_b   = (sz == DEPTH);
    if (m_active && m_edge == m_sstart + FRAME) begin
      if (sz != 0) begin
        m_cur    = mq.pop_front();
        m_sstart = m_edge;
      end else begin
        m_active = 0;
      end
    end else if (!m_active && sz != 0) begin
      m_cur    = mq.pop_front();
      m_sstart = m_edge;
      m_active = 1;
    end
    if (we && a == BASE) begin
      if (full_b) begin
        m_ovf = 1;
        $display("[TB] push 0x%02h dropped (fifo full)", wd[7:0]);
      end else begin
        mq.push_back(wd[7:0]);
        $display("[TB] push 0x%02h accepted, depth %0d", wd[7:0], mq.size());
      end
    end
    if (we && a == BASE + 32'd4 && wd[3]) m_ovf = 0;
  endtask

  // One bus cycle, entered and left at a falling edge.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd);
    write_enable = we;
    addr         = a;
    write_data   = wd;
    #1;
    check("hit", {31'b0, hit}, {31'b0, exp_hit(a)});
    check("read_data", read_data, exp_rd(a));
    @(posedge clk);
    model_step(we, a, wd);
    @(negedge clk);
    check("tx", {31'b0, tx}, {31'b0, exp_tx});
    check("busy", {31'b0, busy}, {31'b0, exp_busy});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || mq.size() != 0) && n < 2000) begin
      cycle(1'b0, BASE + 32'd4, 32'h0);
      n++;
    end
    check("drain_timeout", {31'b0, (n >= 2000)}, 32'h0);
    repeat (3) cycle(1'b0, BASE + 32'd4, 32'h0);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return BASE;
      1:       return BASE + 32'd4;
      2:       return BASE + 32'd8;
      3:       return 32'h0000_0100;
      4:       return BASE + 32'd2;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int op;
    rst_n        = 1'b1;
    write_enable = 1'b0;
    addr         = 32'h0;
    write_data   = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    addr = BASE + 32'd4;
    #1;
    check("reset_status", read_data, 32'h2 | CAP);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b0, BASE, 32'h0);
    check("load_base_hit", {31'b0, hit}, 32'h1);
    check("load_base_rd", read_data, 32'h0);
    cycle(1'b1, BASE + 32'd8, 32'h0000_00AB);
    check("store_b8_hit", {31'b0, hit}, 32'h0);
    cycle(1'b1, 32'h0000_0100, 32'h0000_00CD);
    check("store_100_hit", {31'b0, hit}, 32'h0);
    cycle(1'b0, BASE + 32'd4, 32'h0);
    check("no_push_status", read_data, 32'h2 | CAP);

    cycle(1'b1, BASE, 32'h1234_55A5);
    cycle(1'b0, BASE + 32'd4, 32'h0);
    check("tx_before_fall", {31'b0, tx}, 32'h1);
    cycle(1'b0, BASE + 32'd4, 32'h0);
    check("tx_fall", {31'b0, tx}, 32'h0);
    drain();

    cycle(1'b1, BASE, 32'h0000_0041);
    cycle(1'b1, BASE, 32'h0000_0042);
    cycle(1'b0, BASE + 32'd4, 32'h0);
    check("count_during_A", {24'b0, read_data[15:8]}, 32'h1);
    drain();

    cycle(1'b1, BASE, 32'h0000_0041);
    repeat (2) cycle(1'b0, BASE + 32'd4, 32'h0);
    for (int i = 0; i < 9; i++) cycle(1'b1, BASE, 32'h0000_0060 + i);
    cycle(1'b0, BASE + 32'd4, 32'h0);
    check("fill_status", read_data & ~32'h10, 32'h0000_080D);
    cycle(1'b1, BASE + 32'd4, 32'h0000_0008);
    check("ovf_clear", {31'b0, read_data[3]}, 32'h0);
    drain();

    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 99);
      if (op < 7)       cycle(1'b1, BASE, $urandom);
      else if (op < 10) cycle(1'b1, BASE + 32'd4, $urandom);
      else if (op < 13) cycle(1'b1, BASE + 32'd8, $urandom);
      else if (op < 15) cycle(1'b1, 32'h0000_0100, $urandom);
      else              cycle(1'b0, pick_addr(), $urandom);
    end
    drain();

    for (int i = 0; i < 4; i++) cycle(1'b1, BASE, 32'h0000_00C0 + i);
    n = 0;
    while (!(m_active && (m_edge - m_sstart) == 18) && n < 500) begin
      cycle(1'b0, BASE + 32'd4, 32'h0);
      n++;
    end
    check("reach_data_bit3", {31'b0, (n >= 500)}, 32'h0);
    check("queued_before_reset", mq.size(), 32'd3);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_tx", {31'b0, tx}, 32'h1);
    check("midframe_rst_busy", {31'b0, busy}, 32'h0);
    check("midframe_rst_status", read_data, 32'h2 | CAP);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) cycle(1'b0, BASE + 32'd4, 32'h0);
    check("post_rst_status", read_data, 32'h2 | CAP);
    check("post_rst_tx", {31'b0, tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
